// File: rtl/match_ctrl_if.sv
// Button/score bundle between the match controller and its environment.
// Driver side is the master; the controller consumes it through the slave modport.
interface match_ctrl_if;
  logic       start;
  logic       pointA;
  logic       pointB;
  logic [8:0] scoreA;
  logic [8:0] scoreB;
  logic       serveA;
  logic       match_over;
  logic [1:0] winner;

  modport master (
    output start, pointA, pointB,
    input  scoreA, scoreB, serveA, match_over, winner
  );

  modport slave (
    input  start, pointA, pointB,
    output scoreA, scoreB, serveA, match_over, winner
  );
endinterface

// File: rtl/match_ctrl.sv
// Point/game/match sequencer with win-by-2, 15-point cap and serve rotation.
// Scores update one edge after a button rising edge is seen; no backpressure, off-PLAY events are dropped.
module match_ctrl #(
  parameter int PTS_WIN   = 11,
  parameter int GAMES_WIN = 3,
  parameter int HOLD_CYC  = 4
) (
  input  logic         clk,
  input  logic         rst,
  match_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, GAME_END, MATCH_END} state_t;

  localparam int              HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [3:0]      PW        = 4'(PTS_WIN);
  localparam logic [3:0]      PW1       = 4'(PTS_WIN - 1);
  localparam logic [4:0]      GW        = 5'(GAMES_WIN);

  state_t        state, state_nxt;
  logic          prev_a, prev_b;
  logic [3:0]    pts_a, pts_b;
  logic [4:0]    games_a, games_b;
  logic          serve_a;
  logic          gw_a;
  logic [HW-1:0] hold_cnt;

  logic          ev_a, ev_b, award_a, award_b;
  logic [3:0]    pa_inc, pb_inc;
  logic          win_a, win_b, deuce, serve_tgl, hold_done;

  always_comb begin
    ev_a      = bus.pointA & ~prev_a;
    ev_b      = bus.pointB & ~prev_b;
    award_a   = (state == PLAY) & ev_a & ~ev_b;
    award_b   = (state == PLAY) & ev_b & ~ev_a;
    pa_inc    = pts_a + 4'd1;
    pb_inc    = pts_b + 4'd1;
    win_a     = award_a & (((pa_inc >= PW) && ({1'b0, pa_inc} >= {1'b0, pts_b} + 5'd2))
                           || (pa_inc == 4'hF));
    win_b     = award_b & (((pb_inc >= PW) && ({1'b0, pb_inc} >= {1'b0, pts_a} + 5'd2))
                           || (pb_inc == 4'hF));
    deuce     = award_a ? ((pa_inc >= PW1) && (pts_b >= PW1))
                        : ((pts_a >= PW1) && (pb_inc >= PW1));
    // new total is even exactly when the old total is odd
    serve_tgl = (award_a | award_b) & ((pts_a[0] ^ pts_b[0]) | deuce);
    hold_done = (state == GAME_END) && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = PLAY;
      PLAY:      if (win_a | win_b) state_nxt = GAME_END;
      GAME_END:  if (hold_done)
                   state_nxt = ((gw_a ? games_a : games_b) == GW) ? MATCH_END : PLAY;
      MATCH_END: if (bus.start) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.match_over = (state == MATCH_END);
    bus.winner     = 2'b00;
    if (state == MATCH_END) bus.winner = gw_a ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_a   <= 1'b1;
      prev_b   <= 1'b1;
      pts_a    <= '0;
      pts_b    <= '0;
      games_a  <= '0;
      games_b  <= '0;
      serve_a  <= 1'b1;
      gw_a     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      prev_a <= bus.pointA;
      prev_b <= bus.pointB;
      case (state)
        PLAY: begin
          if (award_a)   pts_a   <= pa_inc;
          if (award_b)   pts_b   <= pb_inc;
          if (serve_tgl) serve_a <= ~serve_a;
          if (win_a) begin
            games_a <= games_a + 5'd1;
            gw_a    <= 1'b1;
          end
          if (win_b) begin
            games_b <= games_b + 5'd1;
            gw_a    <= 1'b0;
          end
          hold_cnt <= '0;
        end
        GAME_END: begin
          if (hold_done) begin
            pts_a    <= '0;
            pts_b    <= '0;
            serve_a  <= ~gw_a;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        MATCH_END: begin
          if (bus.start) begin
            pts_a   <= '0;
            pts_b   <= '0;
            games_a <= '0;
            games_b <= '0;
            serve_a <= 1'b1;
            gw_a    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.scoreA = {games_a, pts_a};
  assign bus.scoreB = {games_b, pts_b};
  assign bus.serveA = serve_a;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed test-plan sequences plus random button traffic, checked against a score-rule model.
module tb_match_ctrl;
  localparam int PTS  = 11;
  localparam int GW   = 3;
  localparam int HOLD = 4;

  localparam int M_IDLE = 0, M_PLAY = 1, M_GEND = 2, M_MEND = 3;

  logic clk, rst;
  match_ctrl_if bus();

  match_ctrl #(.PTS_WIN(PTS), .GAMES_WIN(GW), .HOLD_CYC(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int m_pts[2];
  int m_games[2];
  int m_serve, m_phase, m_hold, m_gw;
  bit m_prev[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pts[0] = 0; m_pts[1] = 0;
    m_games[0] = 0; m_games[1] = 0;
    m_serve = 1; m_phase = M_IDLE; m_hold = 0; m_gw = 0;
    m_prev[0] = 1'b1; m_prev[1] = 1'b1;
  endtask

  task automatic model_edge(input bit a, input bit b, input bit s);
    bit ea, eb;
    int w, l;
    ea = a && !m_prev[0];
    eb = b && !m_prev[1];
    case (m_phase)
      M_IDLE: if (s) m_phase = M_PLAY;
      M_PLAY: if (ea != eb) begin
        w = ea ? 0 : 1;
        l = 1 - w;
        m_pts[w]++;
        if (((m_pts[0] + m_pts[1]) % 2 == 0) || (m_pts[0] >= PTS - 1 && m_pts[1] >= PTS - 1))
          m_serve = 1 - m_serve;
        if ((m_pts[w] >= PTS && m_pts[w] - m_pts[l] >= 2) || m_pts[w] == 15) begin
          m_games[w]++;
          m_gw = w;
          m_hold = HOLD;
          m_phase = M_GEND;
        end
      end
      M_GEND: begin
        m_hold--;
        if (m_hold == 0) begin
          m_pts[0] = 0; m_pts[1] = 0;
          m_serve = (m_gw == 1) ? 1 : 0;
          m_phase = (m_games[m_gw] == GW) ? M_MEND : M_PLAY;
        end
      end
      default: if (s) begin
        m_pts[0] = 0; m_pts[1] = 0;
        m_games[0] = 0; m_games[1] = 0;
        m_serve = 1;
        m_phase = M_IDLE;
      end
    endcase
    m_prev[0] = a;
    m_prev[1] = b;
  endtask

  task automatic check_all();
    chk("scoreA", bus.scoreA, m_games[0] * 16 + m_pts[0]);
    chk("scoreB", bus.scoreB, m_games[1] * 16 + m_pts[1]);
    chk("serveA", bus.serveA, m_serve);
    chk("match_over", bus.match_over, (m_phase == M_MEND) ? 1 : 0);
    chk("winner", bus.winner, (m_phase == M_MEND) ? ((m_gw == 0) ? 1 : 2) : 0);
  endtask

  task automatic step(input bit a, input bit b, input bit s);
    bus.pointA = a;
    bus.pointB = b;
    bus.start  = s;
    @(posedge clk);
    model_edge(a, b, s);
    #1;
    check_all();
  endtask

  task automatic press(input bit a, input bit b);
    step(a, b, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_scoreA", bus.scoreA, 0);
    chk("rst_scoreB", bus.scoreB, 0);
    chk("rst_serveA", bus.serveA, 1);
    chk("rst_over", bus.match_over, 0);
    chk("rst_winner", bus.winner, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int void_serve;
    rst = 1'b1;
    bus.pointA = 1'b1;
    bus.pointB = 1'b0;
    bus.start  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #5 rst = 1'b0;
    #1;
    check_all();

    // button held through reset must not score
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("held_scoreA", bus.scoreA, 9'h000);
    chk("held_serveA", bus.serveA, 1);

    // game 1: 11-0 to A
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
    chk("g1_scoreA", bus.scoreA, 9'b00001_1011);
    chk("g1_scoreB", bus.scoreB, 9'h000);
    idle(HOLD - 1);
    chk("g1_hold_scoreA", bus.scoreA, 9'b00001_0000);
    chk("g1_hold_serveA", bus.serveA, 0);

    // game 2: deuce, A wins 13-11
    for (int i = 0; i < 10; i++) begin
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("g2_scoreA", bus.scoreA, 9'b00010_1101);
    chk("g2_scoreB", bus.scoreB, 9'b00000_1011);
    idle(HOLD - 1);

    // game 3: alternate to 14-14, B takes it at the cap
    for (int i = 0; i < 14; i++) begin
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
    end
    press(1'b0, 1'b1);
    chk("g3_scoreB", bus.scoreB, 9'b00001_1111);
    chk("g3_scoreA", bus.scoreA, 9'b00010_1110);
    idle(HOLD - 1);

    // game 4: void rally at 3-2, then A closes out the match
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) press(1'b0, 1'b1);
    void_serve = m_serve;
    press(1'b1, 1'b1);
    chk("void_scoreA", bus.scoreA, 9'b00010_0011);
    chk("void_scoreB", bus.scoreB, 9'b00001_0010);
    chk("void_serve", bus.serveA, void_serve);
    for (int i = 0; i < 20 && m_phase == M_PLAY; i++) press(1'b1, 1'b0);
    idle(HOLD - 1);
    chk("mend_over", bus.match_over, 1);
    chk("mend_winner", bus.winner, 2'b01);
    chk("mend_scoreA", bus.scoreA, 9'b00011_0000);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("mend_frozen", bus.scoreA, 9'b00011_0000);
    step(1'b0, 1'b0, 1'b1);
    chk("idle_scoreA", bus.scoreA, 0);
    chk("idle_scoreB", bus.scoreB, 0);
    chk("idle_serveA", bus.serveA, 1);
    chk("idle_over", bus.match_over, 0);
    chk("idle_winner", bus.winner, 0);

    // reset mid-game
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    async_reset();
    step(1'b0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
